wb_window_watchdog: RTL

- Single-clock, parametrised successor of the independent watchdog. Adds a refresh window, an early-warning interrupt, a register-write unlock key and sticky status flags.
- Wishbone classic slave in the peripheral register space. The watchdog down-counter is prescaled from the bus clock itself, so there is no separate LSI clock domain.
- rst_wdg feeds the system reset controller; irq_ewi feeds the interrupt controller.

---
 rtl/wb_window_watchdog_if.sv | 30 +++
 rtl/wb_window_watchdog.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_window_watchdog_if.sv
// Wishbone classic bus bundle for the window watchdog register block.
// Signal names follow the m2s (master-to-slave) / s2m (slave-to-master) split.
`timescale 1ns / 1ps

interface wb_window_watchdog_if #(
  parameter int unsigned GRL = 1
) ();

  logic [31:0]  dat_m2s;
  logic [31:0]  adr_m2s;
  logic [GRL:0] sel_m2s;
  logic         cyc_m2s;
  logic         stb_m2s;
  logic         we_m2s;
  logic [31:0]  dat_s2m;
  logic         ack_s2m;
  logic         err_s2m;
  logic         rty_s2m;

  modport master (
    output dat_m2s, adr_m2s, sel_m2s, cyc_m2s, stb_m2s, we_m2s,
    input  dat_s2m, ack_s2m, err_s2m, rty_s2m
  );

  modport slave (
    input  dat_m2s, adr_m2s, sel_m2s, cyc_m2s, stb_m2s, we_m2s,
    output dat_s2m, ack_s2m, err_s2m, rty_s2m
  );

endinterface

// File: rtl/wb_window_watchdog.sv
// Windowed watchdog with early-warning interrupt, key-protected configuration
// and sticky status flags. The down-counter is prescaled from the bus clock.
`timescale 1ns / 1ps

module wb_window_watchdog #(
  parameter int unsigned GRL      = 1,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned PR_W     = 3,
  parameter int unsigned RST_LEN  = 4,
  parameter logic [31:0] BASE_ADR = 32'h0100_0000,
  parameter logic [31:0] KR_ADR   = BASE_ADR + 32'h00,
  parameter logic [31:0] PR_ADR   = BASE_ADR + 32'h04,
  parameter logic [31:0] RLR_ADR  = BASE_ADR + 32'h08,
  parameter logic [31:0] WINR_ADR = BASE_ADR + 32'h0C,
  parameter logic [31:0] EWR_ADR  = BASE_ADR + 32'h10,
  parameter logic [31:0] SR_ADR   = BASE_ADR + 32'h14
) (
  input  logic                       clk_m2s,
  input  logic                       rst_m2s,
  wb_window_watchdog_if.slave        bus,
  output logic                       rst_wdg,
  output logic                       irq_ewi
);

  // Prescaler must reach 2^PR - 1 for the largest PR value.
  localparam int unsigned PscW = (1 << PR_W) - 1;
  localparam int unsigned RcW  = $clog2(RST_LEN + 1);

  localparam logic [15:0] KeyStart   = 16'hCCCC;
  localparam logic [15:0] KeyRefresh = 16'hAAAA;
  localparam logic [15:0] KeyUnlock  = 16'h5555;

  // Bus-side state
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       dat_q, dat_d;

  // Configuration registers
  logic [PR_W-1:0]   pr_q, pr_d;
  logic [CNT_W-1:0]  rlr_q, rlr_d;
  logic [CNT_W-1:0]  winr_q, winr_d;
  logic [CNT_W-1:0]  ewr_q, ewr_d;

  // Status flags
  logic              enabled_q, enabled_d;
  logic              ewif_q, ewif_d;
  logic              rst_to_q, rst_to_d;
  logic              rst_win_q, rst_win_d;
  logic              unlock_q, unlock_d;

  // Watchdog core
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PscW-1:0]   presc_q, presc_d;
  logic [RcW-1:0]    rst_cnt_q, rst_cnt_d;
  logic              rst_wdg_q, rst_wdg_d;

  // Decode and event strobes
  logic [GRL:0]      sel;
  logic              req, wr_en;
  logic              hit_kr, hit_pr, hit_rlr, hit_winr, hit_ewr, hit_sr, hit_any;
  logic [15:0]       key;
  logic [31:0]       rd_val;
  logic [PscW-1:0]   psc_lim;
  logic [CNT_W-1:0]  cnt_dec;
  logic              tick, start, refresh, win_bad, timeout, ew_set, trig;

  assign sel = bus.sel_m2s;

  // Only the low lane carries register data; the rest is intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.dat_m2s[31:16], sel};

  // Address decode, access request and read-data selection.
  always_comb begin
    req      = bus.cyc_m2s & bus.stb_m2s & ~ack_q & ~err_q;
    wr_en    = req & bus.we_m2s & sel[0];
    key      = bus.dat_m2s[15:0];
    hit_kr   = (bus.adr_m2s == KR_ADR);
    hit_pr   = (bus.adr_m2s == PR_ADR);
    hit_rlr  = (bus.adr_m2s == RLR_ADR);
    hit_winr = (bus.adr_m2s == WINR_ADR);
    hit_ewr  = (bus.adr_m2s == EWR_ADR);
    hit_sr   = (bus.adr_m2s == SR_ADR);
    hit_any  = hit_kr | hit_pr | hit_rlr | hit_winr | hit_ewr | hit_sr;

    rd_val = '0;
    if (hit_pr) begin
      rd_val = 32'(pr_q);
    end else if (hit_rlr) begin
      rd_val = 32'(rlr_q);
    end else if (hit_winr) begin
      rd_val = 32'(winr_q);
    end else if (hit_ewr) begin
      rd_val = 32'(ewr_q);
    end else if (hit_sr) begin
      rd_val = 32'({unlock_q, rst_win_q, rst_to_q, ewif_q, enabled_q});
    end

    ack_d = req & hit_any;
    err_d = req & ~hit_any;
    dat_d = (req & ~bus.we_m2s & hit_any) ? rd_val : '0;
  end

  // Tick generation, key commands, window check and event priorities.
  always_comb begin
    for (int i = 0; i < int'(PscW); i++) begin
      psc_lim[i] = (i < int'(pr_q));
    end
    cnt_dec = cnt_q - CNT_W'(1);

    tick    = enabled_q & (presc_q >= psc_lim);
    start   = wr_en & hit_kr & (key == KeyStart);
    // A refresh before the watchdog is started has no effect at all.
    refresh = wr_en & hit_kr & (key == KeyRefresh) & enabled_q;
    win_bad = refresh & (cnt_q > winr_q);
    // Any reload in the same cycle pre-empts a pending timeout or warning.
    timeout = tick & (cnt_q == '0) & ~refresh & ~start;
    ew_set  = tick & (cnt_q != '0) & (cnt_dec == ewr_q) & ~refresh & ~start;
    trig    = timeout | win_bad;

    enabled_d = enabled_q | start;

    cnt_d = cnt_q;
    if (start | refresh) begin
      cnt_d = rlr_q;
    end else if (tick) begin
      cnt_d = (cnt_q == '0) ? rlr_q : cnt_dec;
    end

    presc_d = presc_q;
    if (start | (refresh & ~win_bad)) begin
      presc_d = '0;
    end else if (enabled_q) begin
      presc_d = tick ? '0 : presc_q + PscW'(1);
    end

    unlock_d = unlock_q;
    if (wr_en & hit_kr) begin
      unique case (key)
        KeyUnlock:  unlock_d = 1'b1;
        KeyStart:   unlock_d = unlock_q;
        KeyRefresh: unlock_d = enabled_q ? 1'b0 : unlock_q;
        default:    unlock_d = 1'b0;
      endcase
    end

    pr_d   = pr_q;
    rlr_d  = rlr_q;
    winr_d = winr_q;
    ewr_d  = ewr_q;
    if (wr_en & unlock_q) begin
      if (hit_pr)   pr_d   = bus.dat_m2s[PR_W-1:0];
      if (hit_rlr)  rlr_d  = bus.dat_m2s[CNT_W-1:0];
      if (hit_winr) winr_d = bus.dat_m2s[CNT_W-1:0];
      if (hit_ewr)  ewr_d  = bus.dat_m2s[CNT_W-1:0];
    end

    // Write-one-to-clear first, so a coincident hardware set wins.
    ewif_d    = ewif_q;
    rst_to_d  = rst_to_q;
    rst_win_d = rst_win_q;
    if (wr_en & hit_sr) begin
      if (bus.dat_m2s[1]) ewif_d    = 1'b0;
      if (bus.dat_m2s[2]) rst_to_d  = 1'b0;
      if (bus.dat_m2s[3]) rst_win_d = 1'b0;
    end
    if (ew_set)  ewif_d    = 1'b1;
    if (timeout) rst_to_d  = 1'b1;
    if (win_bad) rst_win_d = 1'b1;

    // Pulse length counter; a new trigger restarts the full length.
    rst_wdg_d = (rst_cnt_q != '0);
    if (trig) begin
      rst_cnt_d = RcW'(RST_LEN);
    end else if (rst_cnt_q != '0) begin
      rst_cnt_d = rst_cnt_q - RcW'(1);
    end else begin
      rst_cnt_d = '0;
    end
  end

  // Bus response registers.
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  // Configuration, status and watchdog counter state.
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      pr_q      <= '0;
      rlr_q     <= '1;
      winr_q    <= '1;
      ewr_q     <= '0;
      enabled_q <= 1'b0;
      ewif_q    <= 1'b0;
      rst_to_q  <= 1'b0;
      rst_win_q <= 1'b0;
      unlock_q  <= 1'b0;
      cnt_q     <= '1;
      presc_q   <= '0;
      rst_cnt_q <= '0;
      rst_wdg_q <= 1'b0;
    end else begin
      pr_q      <= pr_d;
      rlr_q     <= rlr_d;
      winr_q    <= winr_d;
      ewr_q     <= ewr_d;
      enabled_q <= enabled_d;
      ewif_q    <= ewif_d;
      rst_to_q  <= rst_to_d;
      rst_win_q <= rst_win_d;
      unlock_q  <= unlock_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      rst_cnt_q <= rst_cnt_d;
      rst_wdg_q <= rst_wdg_d;
    end
  end

  assign bus.dat_s2m = dat_q;
  assign bus.ack_s2m = ack_q;
  assign bus.err_s2m = err_q;
  assign bus.rty_s2m = 1'b0;
  assign rst_wdg     = rst_wdg_q;
  assign irq_ewi     = ewif_q;

endmodule
